// File: rtl/line_unpack16.sv
// line_unpack16: accepts one 64-bit line and returns its four 16-bit words
// critical-word-first, starting at start_idx and wrapping around the line.
module line_unpack16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] line,
  input  logic [1:0]  start_idx,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] word,
  output logic [1:0]  word_idx,
  output logic        last,
  output logic        busy
);

  localparam int unsigned LINE_W = 64;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LINE_W-1:0]  hold;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   cnt;
  logic               accept;
  logic               xfer;

  // State register; reset returns to IDLE and abandons any held line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept a line in IDLE, leave SEND on the last handshake or flush.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (flush || (last && out_ready)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and handshake qualifiers decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    word      = '0;
    word_idx  = '0;
    last      = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          in_ready = ~flush;
          accept   = in_valid & ~flush;
        end
        SEND: begin
          out_valid = 1'b1;
          busy      = 1'b1;
          word      = hold[{idx, 4'b0000} +: WORD_W];
          word_idx  = idx;
          last      = (cnt == IDX_W'(3));
          xfer      = out_ready;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

  // Line hold register plus word pointer and emitted-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      hold <= line;
      idx  <= start_idx;
      cnt  <= '0;
    end else if (xfer) begin
      idx  <= idx + IDX_W'(1);
      cnt  <= cnt + IDX_W'(1);
    end
  end

endmodule
